// File: rtl/dsp_alu_pkg.sv
// Shared definitions for the DSP post-adder/ALU stage: data width, ALUMODE
// encodings and the three-operand ALU evaluation used by dsp_alu_preg.
package dsp_alu_pkg;

  localparam int DATA_W = 48;
  localparam int SUM_W  = DATA_W + 2;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_NZADD = 4'b0001,
    ALU_NADD  = 4'b0010,
    ALU_ZSUB  = 4'b0011
  } alu_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              co;
  } alu_res_t;

  // S = X + Y + CIN is kept 50 bits wide so the Z >= S borrow test is exact;
  // the 49-bit result sums are enough for R[48], since bit 48 survives truncation.
  function automatic alu_res_t alu_compute(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic [DATA_W-1:0] z,
    input logic              cin,
    input logic [3:0]        am
  );
    logic [SUM_W-1:0]  s;
    logic [DATA_W:0]   t;
    alu_res_t          res;
    s   = SUM_W'(x) + SUM_W'(y) + SUM_W'(cin);
    t   = '0;
    res = '0;
    case (am)
      ALU_ZSUB: begin
        t      = {1'b0, z} - s[DATA_W:0];
        res.r  = t[DATA_W-1:0];
        res.co = ({2'b00, z} >= s);
      end
      ALU_NZADD: begin
        t      = {1'b0, ~z} + s[DATA_W:0];
        res.r  = t[DATA_W-1:0];
        res.co = t[DATA_W];
      end
      ALU_NADD: begin
        t      = {1'b0, z} + s[DATA_W:0];
        res.r  = ~t[DATA_W-1:0];
        res.co = ~t[DATA_W];
      end
      default: begin
        t      = {1'b0, z} + s[DATA_W:0];
        res.r  = t[DATA_W-1:0];
        res.co = t[DATA_W];
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dsp_pattern_detect.sv
// Pattern/pattern-bar compare on the next P value, with the flag registers and
// the PATTERNDETECTPAST history bit. Built only when PATTERN_DETECT_EN is defined.
module dsp_pattern_detect
  import dsp_alu_pkg::*;
#(
  parameter int                PREG    = 1,
  parameter logic [DATA_W-1:0] PATTERN = '0,
  parameter logic [DATA_W-1:0] MASK    = 48'h3FFF_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] p_next,
  output logic              detect,
  output logic              bdetect,
  output logic              detect_past
);

  logic det_n, bdet_n;
  logic det_q, bdet_q, past_q;

  // A set MASK bit forces that position to match.
  assign det_n  = &(~(p_next ^ PATTERN) | MASK);
  assign bdet_n = &(~(p_next ^ ~PATTERN) | MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q  <= 1'b0;
      bdet_q <= 1'b0;
      past_q <= 1'b0;
    end else if (ce) begin
      det_q  <= det_n;
      bdet_q <= bdet_n;
      past_q <= (PREG != 0) ? det_q : det_n;
    end
  end

  assign detect      = (PREG != 0) ? det_q  : det_n;
  assign bdetect     = (PREG != 0) ? bdet_q : bdet_n;
  assign detect_past = past_q;

endmodule

// File: rtl/dsp_alu_preg.sv
// DSP slice post-adder/ALU and P register stage; closes the accumulate loop via P.
// Optional pattern detector is built when the PATTERN_DETECT_EN macro is defined.
module dsp_alu_preg
  import dsp_alu_pkg::*;
#(
  parameter int                PREG       = 1,
  parameter int                ALUMODEREG = 1,
  parameter int                CARRYINREG = 1,
  parameter logic [DATA_W-1:0] PATTERN    = '0,
  parameter logic [DATA_W-1:0] MASK       = 48'h3FFF_0000_0000
) (
  input  logic              CLK,
  input  logic              RSTP,
  input  logic              CEP,
  input  logic              CEALUMODE,
  input  logic              CECARRYIN,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [DATA_W-1:0] Z,
  input  logic [3:0]        ALUMODE,
  input  logic              CARRYIN,
  output logic [DATA_W-1:0] P,
  output logic              CARRYOUT,
  output logic              PATTERNDETECT,
  output logic              PATTERNBDETECT,
  output logic              PATTERNDETECTPAST
);

  logic [3:0]        alumode_q;
  logic              carryin_q;
  logic [3:0]        am;
  logic              cin;
  alu_res_t          res;
  logic [DATA_W-1:0] p_q;
  logic              co_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is tested first so it overrides all clock enables.
  always_ff @(posedge CLK) begin
    if (RSTP) begin
      alumode_q <= '0;
      carryin_q <= 1'b0;
    end else begin
      if (CEALUMODE) alumode_q <= ALUMODE;
      if (CECARRYIN) carryin_q <= CARRYIN;
    end
  end

  assign am  = (ALUMODEREG != 0) ? alumode_q : ALUMODE;
  assign cin = (CARRYINREG != 0) ? carryin_q : CARRYIN;
  assign res = alu_compute(X, Y, Z, cin, am);

  always_ff @(posedge CLK) begin
    if (RSTP) begin
      p_q  <= '0;
      co_q <= 1'b0;
    end else if (CEP) begin
      p_q  <= res.r;
      co_q <= res.co;
    end
  end

  assign P        = (PREG != 0) ? p_q  : res.r;
  assign CARRYOUT = (PREG != 0) ? co_q : res.co;

`ifdef PATTERN_DETECT_EN
  dsp_pattern_detect #(
    .PREG    (PREG),
    .PATTERN (PATTERN),
    .MASK    (MASK)
  ) u_pattern_detect (
    .clk         (CLK),
    .rst         (RSTP),
    .ce          (CEP),
    .p_next      (res.r),
    .detect      (PATTERNDETECT),
    .bdetect     (PATTERNBDETECT),
    .detect_past (PATTERNDETECTPAST)
  );
`else
  assign PATTERNDETECT     = 1'b0;
  assign PATTERNBDETECT    = 1'b0;
  assign PATTERNDETECTPAST = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_alu_preg.sv
// Scoreboard bench for dsp_alu_preg (PREG/ALUMODEREG/CARRYINREG = 1, PATTERN = 0, MASK = 0).
// Stimulus pushes hand-computed results; a monitor pops and compares one cycle later.
module tb_dsp_alu_preg;
  import dsp_alu_pkg::*;

  typedef struct {
    string       name;
    logic [47:0] p;
    logic        co;
    logic        pd;
    logic        pbd;
    logic        pdp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        CLK = 1'b0;
  logic        RSTP = 1'b1;
  logic        CEP = 1'b0;
  logic        CEALUMODE = 1'b1;
  logic        CECARRYIN = 1'b1;
  logic [47:0] X = '0;
  logic [47:0] Y = '0;
  logic [47:0] z_drv = '0;
  logic [47:0] Z;
  logic [3:0]  ALUMODE = 4'b0000;
  logic        CARRYIN = 1'b0;
  logic [47:0] P;
  logic        CARRYOUT, PATTERNDETECT, PATTERNBDETECT, PATTERNDETECTPAST;

  logic z_fb = 1'b0;
  logic issue_v = 1'b0;
  logic held_pd = 1'b0, held_pbd = 1'b0, held_pdp = 1'b0;

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  assign Z = z_fb ? P : z_drv;

  always #5 CLK = ~CLK;

  dsp_alu_preg #(
    .PREG       (1),
    .ALUMODEREG (1),
    .CARRYINREG (1),
    .PATTERN    (48'h0),
    .MASK       (48'h0)
  ) dut (
    .CLK               (CLK),
    .RSTP              (RSTP),
    .CEP               (CEP),
    .CEALUMODE         (CEALUMODE),
    .CECARRYIN         (CECARRYIN),
    .X                 (X),
    .Y                 (Y),
    .Z                 (Z),
    .ALUMODE           (ALUMODE),
    .CARRYIN           (CARRYIN),
    .P                 (P),
    .CARRYOUT          (CARRYOUT),
    .PATTERNDETECT     (PATTERNDETECT),
    .PATTERNBDETECT    (PATTERNBDETECT),
    .PATTERNDETECTPAST (PATTERNDETECTPAST)
  );

  // With PATTERN = 0 and MASK = 0 the flags reduce to P == 0 / P == all-ones.
  function automatic logic pd_of(input logic [47:0] p);
`ifdef PATTERN_DETECT_EN
    return (p == 48'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic pbd_of(input logic [47:0] p);
`ifdef PATTERN_DETECT_EN
    return (p == ONES);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input string field,
                       input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  // Drives one operand set; am_next/cin_next land in the input registers on
  // this edge and so apply to the following operand set.
  task automatic op(input string name, input logic rst, input logic cep,
                    input logic [47:0] x, input logic [47:0] y, input logic [47:0] z,
                    input logic fb, input logic [3:0] am_next, input logic cin_next,
                    input logic [47:0] ep, input logic eco);
    exp_t e;
    @(negedge CLK);
    RSTP    = rst;
    CEP     = cep;
    X       = x;
    Y       = y;
    z_drv   = z;
    z_fb    = fb;
    ALUMODE = am_next;
    CARRYIN = cin_next;
    issue_v = 1'b1;
    e.name  = name;
    e.p     = ep;
    e.co    = eco;
    if (rst) begin
      e.pd  = 1'b0;
      e.pbd = 1'b0;
      e.pdp = 1'b0;
    end else if (cep) begin
      e.pd  = pd_of(ep);
      e.pbd = pbd_of(ep);
      e.pdp = held_pd;
    end else begin
      e.pd  = held_pd;
      e.pbd = held_pbd;
      e.pdp = held_pdp;
    end
    held_pd  = e.pd;
    held_pbd = e.pbd;
    held_pdp = e.pdp;
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic v;
    exp_t e;
    forever begin
      @(posedge CLK);
      v = issue_v;
      #1;
      if (v) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: got an output with no expected entry, expected one queued");
        end else begin
          e = sb.pop_front();
          check(e.name, "P", P, e.p);
          check(e.name, "CARRYOUT", 48'(CARRYOUT), 48'(e.co));
          check(e.name, "PATTERNDETECT", 48'(PATTERNDETECT), 48'(e.pd));
          check(e.name, "PATTERNBDETECT", 48'(PATTERNBDETECT), 48'(e.pbd));
          check(e.name, "PATTERNDETECTPAST", 48'(PATTERNDETECTPAST), 48'(e.pdp));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [47:0] r0, r1, r2;
    r0 = {16'($urandom), $urandom};
    r1 = {16'($urandom), $urandom};
    r2 = {16'($urandom), $urandom};
    repeat (2) @(negedge CLK);

    // Reset beats CEP and CEALUMODE/CECARRYIN: the 0011/1 driven here must not stick.
    op("rst",        1'b1, 1'b1, r0, r1, r2, 1'b0, 4'b0011, 1'b1, 48'h0, 1'b0);
    op("add_carry",  1'b0, 1'b1, ONES, 48'd0, 48'd1, 1'b0, 4'b0011, 1'b1, 48'h0, 1'b1);
    op("sub_pos",    1'b0, 1'b1, 48'd3, 48'd4, 48'd10, 1'b0, 4'b0011, 1'b0, 48'd2, 1'b1);
    op("sub_neg",    1'b0, 1'b1, 48'd5, 48'd0, 48'd3, 1'b0, 4'b0001, 1'b0,
       48'hFFFF_FFFF_FFFE, 1'b0);
    op("nzadd",      1'b0, 1'b1, 48'd10, 48'd0, 48'd5, 1'b0, 4'b0010, 1'b0, 48'd4, 1'b1);
    op("nadd",       1'b0, 1'b1, 48'd2, 48'd0, 48'd1, 1'b0, 4'b0111, 1'b1,
       48'hFFFF_FFFF_FFFC, 1'b1);
    op("am_other",   1'b0, 1'b1, 48'd2, 48'd3, 48'd1, 1'b0, 4'b0000, 1'b0, 48'd7, 1'b0);

    // Accumulate Z = P from a reset, with CEP low on the third cycle.
    op("rst_acc",    1'b1, 1'b1, r1, r2, r0, 1'b0, 4'b0000, 1'b0, 48'h0, 1'b0);
    op("acc1",       1'b0, 1'b1, 48'd5, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd5, 1'b0);
    op("acc2",       1'b0, 1'b1, 48'd5, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd10, 1'b0);
    op("acc_hold",   1'b0, 1'b0, 48'd5, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd10, 1'b0);
    op("acc4",       1'b0, 1'b1, 48'd5, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd15, 1'b0);

    // ALUMODE switched together with operands: add first, subtract one cycle later.
    op("am_lat_add", 1'b0, 1'b1, 48'd1, 48'd0, 48'd10, 1'b0, 4'b0011, 1'b0, 48'd11, 1'b0);
    op("am_lat_sub", 1'b0, 1'b1, 48'd1, 48'd0, 48'd10, 1'b0, 4'b0000, 1'b0, 48'd9, 1'b1);

    // Count down through zero by accumulating -1 from P = 2.
    op("pat_seed",   1'b0, 1'b1, 48'd2, 48'd0, 48'd0, 1'b0, 4'b0000, 1'b0, 48'd2, 1'b0);
    op("pat_p1",     1'b0, 1'b1, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd1, 1'b1);
    op("pat_p0",     1'b0, 1'b1, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'd0, 1'b1);
    op("pat_pff",    1'b0, 1'b1, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, ONES, 1'b0);
    op("pat_pfe",    1'b0, 1'b1, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0,
       48'hFFFF_FFFF_FFFE, 1'b1);

    // Reset mid-accumulate, then a held cycle stays at zero.
    op("rst_mid",    1'b1, 1'b1, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'h0, 1'b0);
    op("rst_hold",   1'b0, 1'b0, ONES, 48'd0, 48'd0, 1'b1, 4'b0000, 1'b0, 48'h0, 1'b0);

    @(negedge CLK);
    issue_v = 1'b0;
    CEP     = 1'b0;
    z_fb    = 1'b0;
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
